// File: rtl/pd_defs_pkg.sv
// pd_defs_pkg: definitions shared by the filter controller files.
//   NUM_SIZE_DFLT, CMD_SIZE_LOG2_DFLT : default operand width and command width (log2)
//   CMP_*                             : comparator command codes
//   filter_state_t                    : controller state encoding
package pd_defs_pkg;

  localparam int NUM_SIZE_DFLT      = 32;
  localparam int CMD_SIZE_LOG2_DFLT = 3;

  // Command codes that are not listed here give a result of 0.
  localparam int CMP_EQ = 0;
  localparam int CMP_NE = 1;
  localparam int CMP_LT = 2;
  localparam int CMP_LE = 3;
  localparam int CMP_GT = 4;
  localparam int CMP_GE = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } filter_state_t;

endpackage

// File: rtl/filter_ctrl_if.sv
// filter_ctrl_if: job configuration, element stream, mask stream and status.
//   cfg_*         : job configuration handshake (cmd, signed operand, element count)
//   in_*          : signed column element stream
//   out_*         : packed mask word stream, out_last marks the final word of a job
//   abort         : cancels the current job
//   busy/done     : job status, done is a one-cycle pulse
//   match_count   : number of result bits equal to 1 in the last job
// Modports: master drives the job (bench/system side), slave is filter_ctrl.
interface filter_ctrl_if
  import pd_defs_pkg::*;
#(
  parameter int NUM_SIZE      = NUM_SIZE_DFLT,
  parameter int CMD_SIZE_LOG2 = CMD_SIZE_LOG2_DFLT,
  parameter int MASK_W        = 32,
  parameter int LEN_W         = 16
) ();

  localparam int CMD_W = 2**CMD_SIZE_LOG2;

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic        [CMD_W-1:0]    cfg_cmd;
  logic signed [NUM_SIZE-1:0] cfg_operand;
  logic        [LEN_W-1:0]    cfg_len;

  logic                       in_valid;
  logic                       in_ready;
  logic signed [NUM_SIZE-1:0] in_data;

  logic                       out_valid;
  logic                       out_ready;
  logic        [MASK_W-1:0]   out_mask;
  logic                       out_last;

  logic                       abort;
  logic                       busy;
  logic                       done;
  logic        [LEN_W-1:0]    match_count;

  modport master (
    output cfg_valid, cfg_cmd, cfg_operand, cfg_len,
    output in_valid, in_data,
    output out_ready,
    output abort,
    input  cfg_ready, in_ready, out_valid, out_mask, out_last,
    input  busy, done, match_count
  );

  modport slave (
    input  cfg_valid, cfg_cmd, cfg_operand, cfg_len,
    input  in_valid, in_data,
    input  out_ready,
    input  abort,
    output cfg_ready, in_ready, out_valid, out_mask, out_last,
    output busy, done, match_count
  );

endinterface

// File: rtl/filter_ctrl_cmp.sv
// filter_ctrl_cmp: signed two-operand comparator, purely combinational.
//   i_in1, i_in2 : signed operands
//   i_cmd        : command code (CMP_* in pd_defs_pkg), unknown codes give 0
//   o_result     : 1 when "i_in1 <cmd> i_in2" holds
module filter_ctrl_cmp
  import pd_defs_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DFLT,
  parameter int CMD_W    = 2**CMD_SIZE_LOG2_DFLT
) (
  input  logic signed [NUM_SIZE-1:0] i_in1,
  input  logic signed [NUM_SIZE-1:0] i_in2,
  input  logic        [CMD_W-1:0]    i_cmd,
  output logic                       o_result
);

  always_comb begin
    o_result = 1'b0;
    case (i_cmd)
      CMD_W'(CMP_EQ): o_result = (i_in1 == i_in2);
      CMD_W'(CMP_NE): o_result = (i_in1 != i_in2);
      CMD_W'(CMP_LT): o_result = (i_in1 <  i_in2);
      CMD_W'(CMP_LE): o_result = (i_in1 <= i_in2);
      CMD_W'(CMP_GT): o_result = (i_in1 >  i_in2);
      CMD_W'(CMP_GE): o_result = (i_in1 >= i_in2);
      default:        o_result = 1'b0;
    endcase
  end

endmodule

// File: rtl/filter_ctrl.sv
// filter_ctrl: streams a column of signed elements through one comparator and
// packs the per-element results into MASK_W-bit mask words, bit 0 first.
// Ports:
//   clk   : single clock
//   reset : asynchronous, active-high
//   bus   : filter_ctrl_if.slave (config, element stream, mask stream, status)
// Build option FILTER_CTRL_MATCH_COUNT_EN: match_count counts result bits equal
// to 1, saturating; without it match_count is tied to 0.
//
// state | meaning
// IDLE  | cfg_ready high, waiting for a job
// RUN   | accepting the job's len elements
// FLUSH | final result merging, final word waiting for its handshake
// DONE  | job finished; done pulses on the following cycle
module filter_ctrl
  import pd_defs_pkg::*;
#(
  parameter int NUM_SIZE      = NUM_SIZE_DFLT,
  parameter int CMD_SIZE_LOG2 = CMD_SIZE_LOG2_DFLT,
  parameter int MASK_W        = 32,
  parameter int LEN_W         = 16
) (
  input  logic         clk,
  input  logic         reset,
  filter_ctrl_if.slave bus
);

  localparam int CMD_W = 2**CMD_SIZE_LOG2;
  localparam int IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1;

  filter_state_t r_state, w_state_nxt;

  logic        [CMD_W-1:0]    r_cmd;
  logic signed [NUM_SIZE-1:0] r_operand;
  logic        [LEN_W-1:0]    r_len;
  logic        [LEN_W-1:0]    r_cnt;
  logic        [IDX_W-1:0]    r_bit_idx;
  logic        [MASK_W-1:0]   r_acc;
  logic                       r_res_valid;
  logic                       r_res_bit;
  logic                       r_res_last;
  logic                       r_out_valid;
  logic        [MASK_W-1:0]   r_out_mask;
  logic                       r_out_last;
  logic                       r_done;

  logic              w_cfg_ready;
  logic              w_in_ready;
  logic              w_busy;
  logic              w_cfg_fire;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_out_free;
  logic              w_last_elem;
  logic              w_word_full;
  logic              w_merge;
  logic              w_word_push;
  logic              w_cmp_res;
  logic [MASK_W-1:0] w_merged_word;

  filter_ctrl_cmp #(
    .NUM_SIZE (NUM_SIZE),
    .CMD_W    (CMD_W)
  ) dut (
    .i_in1    (bus.in_data),
    .i_in2    (r_operand),
    .i_cmd    (r_cmd),
    .o_result (w_cmp_res)
  );

  assign w_last_elem = (r_cnt == (r_len - LEN_W'(1)));
  assign w_out_fire  = r_out_valid && bus.out_ready;
  assign w_out_free  = !r_out_valid || bus.out_ready;
  assign w_word_full = r_res_last || (r_bit_idx == IDX_W'(MASK_W - 1));
  // A result that completes a word waits in its register while the output
  // word is still unaccepted; in_ready is low then, so nothing overwrites it.
  assign w_merge       = r_res_valid && (!w_word_full || w_out_free);
  assign w_word_push   = w_merge && w_word_full;
  assign w_merged_word = r_acc | ({{(MASK_W-1){1'b0}}, r_res_bit} << r_bit_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          w_state_nxt = (bus.cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        w_busy     = 1'b1;
        w_in_ready = !(r_out_valid && !bus.out_ready);
        if (bus.in_valid && w_in_ready && w_last_elem) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_busy = 1'b1;
        if (w_out_fire && r_out_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.abort) begin
      w_state_nxt = IDLE;
    end
  end

  assign w_cfg_fire = bus.cfg_valid && w_cfg_ready;
  assign w_in_fire  = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd       <= '0;
      r_operand   <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_res_bit   <= 1'b0;
      r_res_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.abort) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);

      if (w_cfg_fire) begin
        r_cmd     <= bus.cfg_cmd;
        r_operand <= bus.cfg_operand;
        r_len     <= bus.cfg_len;
        r_cnt     <= '0;
        r_bit_idx <= '0;
        r_acc     <= '0;
      end

      if (w_in_fire) begin
        r_cnt       <= r_cnt + LEN_W'(1);
        r_res_valid <= 1'b1;
        r_res_bit   <= w_cmp_res;
        r_res_last  <= w_last_elem;
      end else if (w_merge) begin
        r_res_valid <= 1'b0;
      end

      if (w_merge) begin
        if (w_word_full) begin
          r_acc     <= '0;
          r_bit_idx <= '0;
        end else begin
          r_acc     <= w_merged_word;
          r_bit_idx <= r_bit_idx + IDX_W'(1);
        end
      end

      if (w_word_push) begin
        r_out_valid <= 1'b1;
        r_out_mask  <= w_merged_word;
        r_out_last  <= r_res_last;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

`ifdef FILTER_CTRL_MATCH_COUNT_EN
  logic [LEN_W-1:0] r_match_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match_count <= '0;
    end else if (!bus.abort) begin
      if (w_cfg_fire) begin
        r_match_count <= '0;
      end else if (w_merge && r_res_bit && (r_match_count != {LEN_W{1'b1}})) begin
        r_match_count <= r_match_count + LEN_W'(1);
      end
    end
  end

  assign bus.match_count = r_match_count;
`else
  assign bus.match_count = '0;
`endif

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_mask  = r_out_mask;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;

endmodule

// File: doc/filter_ctrl.md
FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 32, operand width in bits (signed).
REQ-002 SHALL have parameter CMD_SIZE_LOG2, default 3, comparator command width is 2**CMD_SIZE_LOG2.
REQ-003 SHALL have parameter MASK_W, default 32, result bits per mask word.
REQ-004 SHALL have parameter LEN_W, default 16, element-count width.
REQ-005 SHALL have ports: clk  in  1  single clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: cfg_valid in 1; cfg_ready out 1; cfg_cmd in 2**CMD_SIZE_LOG2; cfg_operand in NUM_SIZE signed; cfg_len in LEN_W, element count.
REQ-007 SHALL have ports: in_valid in 1; in_ready out 1; in_data in NUM_SIZE signed, column element.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_mask out MASK_W; out_last out 1, final word of job.
REQ-009 SHALL have ports: abort in 1, cancels job; busy out 1; done out 1, one-cycle pulse; match_count out LEN_W.

Function
REQ-010 SHALL sequence one comparator instance: in1=in_data, in2=latched operand, cmd=latched cmd; comparator result is registered, valid one cycle after the element is accepted.
REQ-011 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-012 IDLE: cfg_ready=1; a cfg_valid&cfg_ready cycle latches cmd, operand, len; goes to RUN if len>0, else DONE.
REQ-013 cfg_ready SHALL be 0 outside IDLE; cfg_valid is ignored there.
REQ-014 RUN: in_ready = !(out_valid & !out_ready); element accepted on in_valid&in_ready; after the len-th element, goes to FLUSH.
REQ-015 Result of element k SHALL be written to mask bit (k mod MASK_W), bit 0 first.
REQ-016 A word SHALL move to the output register when MASK_W bits are collected or the job's last bit arrives; unused upper bits of a partial word are 0; out_last=1 only on the final word.
REQ-017 out_valid/out_mask/out_last SHALL hold stable until out_valid&out_ready.
REQ-018 FLUSH: waits for the final result and the final word's handshake, then goes to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; match_count holds its value until the next accepted config, which clears it.
REQ-020 len=0: no mask word is emitted, done pulses two cycles after config acceptance, match_count=0.
REQ-021 abort in any state SHALL return to IDLE next cycle, clear out_valid and the accumulator, and not pulse done; abort takes priority over all simultaneous events.
REQ-022 busy SHALL be 1 in RUN, FLUSH, DONE.
REQ-023 Command values SHALL pass to the comparator unmodified; their meaning is defined by the comparator.

Reset
REQ-024 reset SHALL force state IDLE; cfg_ready=1; in_ready, out_valid, out_last, done, busy=0; out_mask, match_count, accumulator, element counter=0, including mid-job.

Configuration
REQ-025 Macro FILTER_CTRL_MATCH_COUNT_EN defined: match_count increments by 1 per result bit equal to 1, saturating at 2**LEN_W-1.
REQ-026 Macro FILTER_CTRL_MATCH_COUNT_EN undefined: no counter logic; match_count is tied to 0.

Structure
REQ-027 NUM_SIZE, CMD_SIZE_LOG2 defaults and the state enum typedef SHALL live in shared package pd_defs_pkg.
REQ-028 The comparator SHALL be the single sub-module, instance of dut; no other sub-modules.

Verification
REQ-029 len=5, cmd=greater-than, operand=10, data 3,12,10,11,-4, out_ready=1 -> one word out_mask=0x0000000A, out_last=1; done pulse; match_count=2.
REQ-030 len=40, all data 1, operand 0, cmd=greater-than -> word0=0xFFFFFFFF out_last=0, word1=0x000000FF out_last=1, match_count=40.
REQ-031 len=33, out_ready held 0 for 10 cycles after first word -> in_ready=0 for those cycles, out_mask stable, no element lost; final match_count matches the golden model.
REQ-032 len=0 -> no out_valid; done two cycles after config; match_count=0.
REQ-033 abort after 7 of 20 elements -> IDLE next cycle, out_valid=0, no done; new len=3 job runs correctly.
REQ-034 reset asserted mid-RUN -> all outputs at reset values asynchronously; with macro undefined, match_count stays 0 throughout.
